// File: rtl/sample_readout_fifo.sv
// In-order read buffer for FIR results; a read is accepted on RD_EN when not empty, data and DATA_VALID appear 1 edge later.
// Writes to a full buffer with no accepted read are dropped and flag OVERFLOW; reads while empty flag UNDERFLOW.
module sample_readout_fifo #(
    parameter int  WIDTH = 16,
    parameter int  DEPTH = 8,
    localparam int AW    = $clog2(DEPTH)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             WR_EN,
    input  logic [WIDTH-1:0] DATA_IN,
    input  logic             RD_EN,
    output logic [WIDTH-1:0] DATA_OUT,
    output logic             DATA_VALID,
    output logic             EMPTY,
    output logic             FULL,
    output logic [AW:0]      COUNT,
    output logic             OVERFLOW,
    output logic             UNDERFLOW
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wptr;
    logic [AW-1:0]    rptr;
    logic             rd_acc;
    logic             wr_acc;
    logic [AW:0]      count_nxt;

    // A write into a full buffer is only safe when a read frees a slot on the same edge.
    assign rd_acc = RD_EN & ~EMPTY;
    assign wr_acc = WR_EN & (~FULL | rd_acc);

    always_comb begin
        count_nxt = COUNT;
        if (wr_acc && !rd_acc) begin
            count_nxt = COUNT + (AW+1)'(1);
        end else if (rd_acc && !wr_acc) begin
            count_nxt = COUNT - (AW+1)'(1);
        end
    end

    always_ff @(posedge CLK) begin
        if (wr_acc) begin
            mem[wptr] <= DATA_IN;
        end
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            wptr       <= '0;
            rptr       <= '0;
            DATA_OUT   <= '0;
            DATA_VALID <= 1'b0;
            EMPTY      <= 1'b1;
            FULL       <= 1'b0;
            COUNT      <= '0;
            OVERFLOW   <= 1'b0;
            UNDERFLOW  <= 1'b0;
        end else begin
            if (wr_acc) begin
                wptr <= wptr + AW'(1);
            end
            if (rd_acc) begin
                rptr     <= rptr + AW'(1);
                DATA_OUT <= mem[rptr];
            end
            DATA_VALID <= rd_acc;
            COUNT      <= count_nxt;
            EMPTY      <= (count_nxt == '0);
            FULL       <= (count_nxt == (AW+1)'(DEPTH));
            OVERFLOW   <= OVERFLOW  | (WR_EN & ~wr_acc);
            UNDERFLOW  <= UNDERFLOW | (RD_EN & ~rd_acc);
        end
    end

endmodule

// File: tb/tb_sample_readout_fifo.sv
// Bench for sample_readout_fifo: vector table plus hand sequences, queue model and output scoreboard.
module tb_sample_readout_fifo;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             WR_EN;
    logic [WIDTH-1:0] DATA_IN;
    logic             RD_EN;
    logic [WIDTH-1:0] DATA_OUT;
    logic             DATA_VALID;
    logic             EMPTY;
    logic             FULL;
    logic [3:0]       COUNT;
    logic             OVERFLOW;
    logic             UNDERFLOW;

    sample_readout_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .CLK(CLK), .RESET(RESET), .WR_EN(WR_EN), .DATA_IN(DATA_IN), .RD_EN(RD_EN),
        .DATA_OUT(DATA_OUT), .DATA_VALID(DATA_VALID), .EMPTY(EMPTY), .FULL(FULL),
        .COUNT(COUNT), .OVERFLOW(OVERFLOW), .UNDERFLOW(UNDERFLOW)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        logic        wr;
        logic [15:0] din;
        logic        rd;
        int          e_count;
        logic        e_valid;
        logic [15:0] e_dout;
        logic        e_ovf;
        logic        e_unf;
    } vec_t;

    int          errors = 0;
    int          checks = 0;
    logic [15:0] mdl[$];
    logic [15:0] exp_q[$];
    logic [15:0] hold;
    logic [15:0] last_out;
    logic        movf;
    logic        munf;
    int          max_count;
    vec_t        vecs[$];
    logic [15:0] got[20];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic vec_t mk(input logic wr, input logic [15:0] din, input logic rd,
                                input int c, input logic v, input logic [15:0] d,
                                input logic o, input logic u);
        vec_t x;
        x.wr = wr; x.din = din; x.rd = rd; x.e_count = c;
        x.e_valid = v; x.e_dout = d; x.e_ovf = o; x.e_unf = u;
        return x;
    endfunction

    task automatic do_reset();
        RESET   = 1'b1;
        WR_EN   = 1'b0;
        RD_EN   = 1'b0;
        DATA_IN = '0;
        mdl.delete();
        exp_q.delete();
        hold = '0;
        movf = 1'b0;
        munf = 1'b0;
        repeat (2) @(posedge CLK);
        @(negedge CLK);
        RESET = 1'b0;
    endtask

    // Drive one cycle, advance the reference model, then check the DUT just after the edge.
    task automatic cycle(input logic wr, input logic [15:0] din, input logic rd);
        logic        rd_acc;
        logic        wr_acc;
        logic [15:0] e;
        @(negedge CLK);
        WR_EN   = wr;
        DATA_IN = din;
        RD_EN   = rd;
        rd_acc  = rd && (mdl.size() != 0);
        wr_acc  = wr && ((mdl.size() < DEPTH) || rd_acc);
        if (rd_acc) begin
            hold = mdl.pop_front();
            exp_q.push_back(hold);
        end
        if (wr_acc) mdl.push_back(din);
        if (wr && !wr_acc) movf = 1'b1;
        if (rd && !rd_acc) munf = 1'b1;
        @(posedge CLK);
        #1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        chk("count", COUNT, mdl.size());
        chk("empty", EMPTY, mdl.size() == 0);
        chk("full", FULL, mdl.size() == DEPTH);
        chk("overflow", OVERFLOW, movf);
        chk("underflow", UNDERFLOW, munf);
        chk("data_valid", DATA_VALID, rd_acc);
        if (DATA_VALID) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_spurious: DATA_VALID with data %0d but no read expected", DATA_OUT);
            end else begin
                e = exp_q.pop_front();
                chk("sb_data", DATA_OUT, e);
                last_out = DATA_OUT;
            end
        end else begin
            chk("data_hold", DATA_OUT, hold);
        end
        if (int'(COUNT) > max_count) max_count = int'(COUNT);
    endtask

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        RESET = 1'b1;
        WR_EN = 1'b0;
        RD_EN = 1'b0;
        DATA_IN = '0;
        #1;
        chk("rst_data_out", DATA_OUT, 0);
        chk("rst_valid", DATA_VALID, 0);
        chk("rst_empty", EMPTY, 1);
        chk("rst_full", FULL, 0);
        chk("rst_count", COUNT, 0);
        chk("rst_ovf", OVERFLOW, 0);
        chk("rst_unf", UNDERFLOW, 0);
        do_reset();

        // Underflow, basic ordering, fill to full, overflow drop, drain.
        vecs.push_back(mk(0, 0, 1, 0, 0, 0, 0, 1));
        vecs.push_back(mk(1, 350, 0, 1, 0, 0, 0, 1));
        vecs.push_back(mk(1, 351, 0, 2, 0, 0, 0, 1));
        vecs.push_back(mk(1, 352, 0, 3, 0, 0, 0, 1));
        vecs.push_back(mk(0, 0, 1, 2, 1, 350, 0, 1));
        vecs.push_back(mk(0, 0, 1, 1, 1, 351, 0, 1));
        vecs.push_back(mk(0, 0, 1, 0, 1, 352, 0, 1));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(1, 16'(100 + i), 0, i + 1, 0, 352, 0, 1));
        vecs.push_back(mk(1, 999, 0, 8, 0, 352, 1, 1));
        for (int i = 0; i < 8; i++) vecs.push_back(mk(0, 0, 1, 7 - i, 1, 16'(100 + i), 1, 1));

        for (int i = 0; i < vecs.size(); i++) begin
            cycle(vecs[i].wr, vecs[i].din, vecs[i].rd);
            chk($sformatf("vec%0d_count", i), COUNT, vecs[i].e_count);
            chk($sformatf("vec%0d_valid", i), DATA_VALID, vecs[i].e_valid);
            chk($sformatf("vec%0d_dout", i), DATA_OUT, vecs[i].e_dout);
            chk($sformatf("vec%0d_ovf", i), OVERFLOW, vecs[i].e_ovf);
            chk($sformatf("vec%0d_unf", i), UNDERFLOW, vecs[i].e_unf);
        end
        chk("t1_empty_end", EMPTY, 1);

        // Simultaneous read and write while full.
        do_reset();
        for (int i = 0; i < 8; i++) cycle(1, 16'(200 + i), 0);
        chk("t4_full", FULL, 1);
        cycle(1, 500, 1);
        chk("t4_oldest", DATA_OUT, 200);
        chk("t4_count", COUNT, 8);
        chk("t4_no_ovf", OVERFLOW, 0);
        for (int i = 0; i < 8; i++) cycle(0, 0, 1);
        chk("t4_last_500", last_out, 500);
        chk("t4_empty", EMPTY, 1);

        // Interleaved pairs wrap both pointers several times.
        do_reset();
        max_count = 0;
        for (int i = 0; i < 20; i++) begin
            cycle(1, 16'(i), 0);
            cycle(0, 0, 1);
            got[i] = DATA_OUT;
        end
        for (int i = 0; i < 20; i++) chk($sformatf("t5_order%0d", i), got[i], i);
        chk("t5_max_count_le1", max_count <= 1, 1);

        // Asynchronous reset in the middle of a cycle.
        do_reset();
        for (int i = 0; i < 5; i++) cycle(1, 16'(600 + i), 0);
        cycle(0, 0, 1);
        chk("t6_pre_dout", DATA_OUT, 600);
        #2;
        RESET = 1'b1;
        #1;
        chk("t6_async_dout", DATA_OUT, 0);
        chk("t6_async_valid", DATA_VALID, 0);
        chk("t6_async_empty", EMPTY, 1);
        chk("t6_async_full", FULL, 0);
        chk("t6_async_count", COUNT, 0);
        chk("t6_async_ovf", OVERFLOW, 0);
        chk("t6_async_unf", UNDERFLOW, 0);
        mdl.delete();
        exp_q.delete();
        hold = '0;
        movf = 1'b0;
        munf = 1'b0;
        @(negedge CLK);
        RESET = 1'b0;
        cycle(1, 7, 0);
        cycle(0, 0, 1);
        chk("t6_after_dout", DATA_OUT, 7);
        chk("t6_after_valid", DATA_VALID, 1);

        chk("sb_leftover", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
